pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// - Sequences the execute stage: load-use interlock, branch-redirect flush, multi-cycle ALU-op hold.
// - Drives register-operand forwarding selects.
// - Sits beside decode/execute; consumes decode source info, EX/MEM destination info and the EX branch decision.
// - Emits stall/bubble/flush/hold controls to fetch, decode and execute.
// PARAMETERS
// - MD_LATENCY    32  cycles a multi-cycle op occupies execute (>=2)
// - FLUSH_CYCLES  2   bubble cycles into fetch/decode after a taken branch (>=1)
// PORTS
// - clk              in   1   clock, rising edge
// - rst_n            in   1   asynchronous active-low reset
// - dec_valid        in   1   decode holds a valid instruction
// - dec_rs1_addr     in   5   decode source 1 address
// - dec_rs2_addr     in   5   decode source 2 address
// - dec_uses_rs1     in   1   instruction reads rs1
// - dec_uses_rs2     in   1   instruction reads rs2
// - dec_multicycle   in   1   instruction is a multi-cycle ALU op
// - ex_write_reg     in   1   EX instruction writes a register
// - ex_dstreg_addr   in   5   EX destination address
// - ex_is_load       in   1   EX instruction is a load (info_load != 0)
// - mem_write_reg    in   1   MEM instruction writes a register
// - mem_dstreg_addr  in   5   MEM destination address
// - br_taken         in   1   EX branch/jump resolved taken
// - stall_f          out  1   hold PC
// - stall_d          out  1   hold decode register
// - bubble_e         out  1   insert NOP into execute register
// - flush_fd         out  1   squash fetch/decode contents
// - ex_hold          out  1   hold execute register (multi-cycle op running)
// - md_start         out  1   one-cycle start pulse to multi-cycle unit
// - md_done          out  1   one-cycle pulse on last multi-cycle cycle
// - fwd_rs1_sel      out  2   00 regfile, 01 EX result, 10 MEM result
// - fwd_rs2_sel      out  2   same encoding for rs2
// BEHAVIOUR
// - Reset: state RUN, counters 0; md_start/md_done/ex_hold/flush_fd = 0.
// - Reset: with idle inputs, every output is 0.
// - Reset mid-operation aborts MD/FLUSH immediately (async); no md_done is emitted.
// - Forwarding (combinational):
//   - EX match has priority over MEM match.
//   - Match = write_reg & dst == rs & dst != 0 & uses_rs.
//   - Register x0 is never forwarded.
// - Load-use (combinational, RUN only):
//   - dec_valid & ex_is_load & EX match on a used rs -> stall_f = stall_d = bubble_e = 1 for that cycle.
//   - 1-cycle penalty; on the next cycle the match resolves via MEM forwarding.
// - FSM states RUN, MD, FLUSH, registered.
//   - RUN -> FLUSH: br_taken. flush_fd = 1 combinationally this cycle; cnt <= FLUSH_CYCLES-1.
//   - RUN -> MD: dec_valid & dec_multicycle, with no load-use hazard and no br_taken.
//     - md_start = 1 this cycle; cnt <= MD_LATENCY-1.
//   - FLUSH: flush_fd = 1; cnt decrements; cnt == 0 -> RUN. If FLUSH_CYCLES == 1, FLUSH is skipped.
//   - MD: ex_hold = stall_f = stall_d = 1; cnt decrements.
//     - cnt == 0 -> md_done = 1, ex_hold released next cycle, -> RUN.
// - Priority same cycle: br_taken > load-use > multicycle start.
//   - Taken branch squashes the younger hazard: no stall, no md_start.
// - br_taken while in MD or FLUSH is ignored (cannot legally occur; assert in simulation).
// - Counter width clog2(max(MD_LATENCY, FLUSH_CYCLES)); no wrap, saturates at 0.
// CONFIGURATION
// - PERF_COUNTERS_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
//   - perf_stall_cnt increments per cycle stall_d == 1; perf_flush_cnt per cycle flush_fd == 1.
//   - Both wrap at 2^32; reset to 0.
// - Macro undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - EX: write x5, not load; decode uses rs1 = x5 -> fwd_rs1_sel = 01, no stall.
// - EX and MEM both write x7; decode uses rs2 = x7 -> fwd_rs2_sel = 01.
// - EX load to x3; decode uses rs1 = x3 -> stall_f/stall_d/bubble_e = 1 for exactly 1 cycle; next cycle fwd_rs1_sel = 10.
// - EX writes x0; decode uses x0 -> fwd selects 00, no stall.
// - br_taken = 1 with FLUSH_CYCLES = 2, concurrent load-use -> flush_fd high 2 cycles, no stall, returns to RUN.
// - Multi-cycle op with MD_LATENCY = 4:
//   - md_start pulses once; ex_hold high 4 cycles; md_done on 4th cycle.
//   - rst_n low in cycle 2 -> all outputs 0, no md_done.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: decode/EX/MEM hazard info into the controller,
// stall/flush/hold/forwarding controls out of it.
interface pipeline_hazard_ctrl_if;
  logic       dec_valid;
  logic [4:0] dec_rs1_addr;
  logic [4:0] dec_rs2_addr;
  logic       dec_uses_rs1;
  logic       dec_uses_rs2;
  logic       dec_multicycle;
  logic       ex_write_reg;
  logic [4:0] ex_dstreg_addr;
  logic       ex_is_load;
  logic       mem_write_reg;
  logic [4:0] mem_dstreg_addr;
  logic       br_taken;
  logic       stall_f;
  logic       stall_d;
  logic       bubble_e;
  logic       flush_fd;
  logic       ex_hold;
  logic       md_start;
  logic       md_done;
  logic [1:0] fwd_rs1_sel;
  logic [1:0] fwd_rs2_sel;

  modport master (
    output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
           dec_multicycle, ex_write_reg, ex_dstreg_addr, ex_is_load,
           mem_write_reg, mem_dstreg_addr, br_taken,
    input  stall_f, stall_d, bubble_e, flush_fd, ex_hold, md_start, md_done,
           fwd_rs1_sel, fwd_rs2_sel
  );

  modport slave (
    input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
           dec_multicycle, ex_write_reg, ex_dstreg_addr, ex_is_load,
           mem_write_reg, mem_dstreg_addr, br_taken,
    output stall_f, stall_d, bubble_e, flush_fd, ex_hold, md_start, md_done,
           fwd_rs1_sel, fwd_rs2_sel
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Execute-stage sequencer: forwarding selects, load-use interlock, branch flush
// and multi-cycle op hold. Define PERF_COUNTERS_EN to add stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_hazard_ctrl_if.slave   hz
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_flush_cnt
`endif
);

  localparam int CNT_MAX = (MD_LATENCY > FLUSH_CYCLES) ? MD_LATENCY : FLUSH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MD_LOAD    = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {ST_RUN, ST_MD, ST_FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [4:0] rs_addr [2];
  logic [1:0] rs_uses;
  logic [1:0] ex_match;
  logic [1:0] mem_match;
  logic [1:0] fwd_sel [2];

  assign rs_addr[0] = hz.dec_rs1_addr;
  assign rs_addr[1] = hz.dec_rs2_addr;
  assign rs_uses    = {hz.dec_uses_rs2, hz.dec_uses_rs1};

  // x0 is hardwired zero, so a write to it must never shadow the regfile read
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign ex_match[gi]  = hz.ex_write_reg & rs_uses[gi] &
                           (hz.ex_dstreg_addr == rs_addr[gi]) & (hz.ex_dstreg_addr != 5'd0);
    assign mem_match[gi] = hz.mem_write_reg & rs_uses[gi] &
                           (hz.mem_dstreg_addr == rs_addr[gi]) & (hz.mem_dstreg_addr != 5'd0);
    assign fwd_sel[gi]   = ex_match[gi]  ? 2'b01 :
                           mem_match[gi] ? 2'b10 : 2'b00;
  end

  assign hz.fwd_rs1_sel = fwd_sel[0];
  assign hz.fwd_rs2_sel = fwd_sel[1];

  logic load_use;
  assign load_use = hz.dec_valid & hz.ex_is_load & (|ex_match);

  logic stall_f, stall_d, bubble_e, flush_fd, ex_hold, md_start, md_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    bubble_e   = 1'b0;
    flush_fd   = 1'b0;
    ex_hold    = 1'b0;
    md_start   = 1'b0;
    md_done    = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (hz.br_taken) begin
          // The branch cycle itself is the first flush cycle
          flush_fd = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next = ST_FLUSH;
            cnt_next   = FLUSH_LOAD;
          end
        end else if (load_use) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end else if (hz.dec_valid && hz.dec_multicycle) begin
          md_start   = 1'b1;
          state_next = ST_MD;
          cnt_next   = MD_LOAD;
        end
      end
      ST_FLUSH: begin
        flush_fd = 1'b1;
        // Leave as the count reaches zero so the total flush equals FLUSH_CYCLES
        if (cnt_reg <= CNT_ONE) begin
          cnt_next   = '0;
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      ST_MD: begin
        ex_hold = 1'b1;
        stall_f = 1'b1;
        stall_d = 1'b1;
        if (cnt_reg == '0) begin
          md_done    = 1'b1;
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  assign hz.stall_f  = stall_f;
  assign hz.stall_d  = stall_d;
  assign hz.bubble_e = bubble_e;
  assign hz.flush_fd = flush_fd;
  assign hz.ex_hold  = ex_hold;
  assign hz.md_start = md_start;
  assign hz.md_done  = md_done;

  // A branch cannot resolve while execute is held or the front end is flushing
  assert property (@(posedge clk) disable iff (!rst_n)
                   !((state_reg != ST_RUN) && hz.br_taken));

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_d)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_fd) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MD_LATENCY=4, FLUSH_CYCLES=2.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz();

`ifdef PERF_COUNTERS_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hz             (hz.slave)
`ifdef PERF_COUNTERS_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  function automatic logic [10:0] outs();
    return {hz.stall_f, hz.stall_d, hz.bubble_e, hz.flush_fd, hz.ex_hold,
            hz.md_start, hz.md_done, hz.fwd_rs1_sel, hz.fwd_rs2_sel};
  endfunction

  task automatic set_idle();
    hz.dec_valid = 0; hz.dec_rs1_addr = 0; hz.dec_rs2_addr = 0;
    hz.dec_uses_rs1 = 0; hz.dec_uses_rs2 = 0; hz.dec_multicycle = 0;
    hz.ex_write_reg = 0; hz.ex_dstreg_addr = 0; hz.ex_is_load = 0;
    hz.mem_write_reg = 0; hz.mem_dstreg_addr = 0; hz.br_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    #2;
    checks++;
    if (outs() !== 11'd0) begin
      fails++; $display("FAIL reset_outs: got %b want %b", outs(), 11'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if (outs() !== 11'd0) begin
      fails++; $display("FAIL post_reset_outs: got %b want %b", outs(), 11'd0);
    end
    $display("test_reset done");
  endtask

  task automatic test_forwarding();
    set_idle();
    hz.dec_valid = 1; hz.dec_uses_rs1 = 1; hz.dec_rs1_addr = 5;
    hz.ex_write_reg = 1; hz.ex_dstreg_addr = 5;
    #1;
    checks++;
    if (hz.fwd_rs1_sel !== 2'b01) begin fails++; $display("FAIL fwd_ex_rs1: got %b want 01", hz.fwd_rs1_sel); end
    checks++;
    if ({hz.stall_f, hz.stall_d, hz.bubble_e, hz.fwd_rs2_sel} !== 5'b0) begin
      fails++; $display("FAIL fwd_ex_nostall: got %b want 00000", {hz.stall_f, hz.stall_d, hz.bubble_e, hz.fwd_rs2_sel});
    end
    tick();
    set_idle();
    hz.dec_valid = 1; hz.dec_uses_rs2 = 1; hz.dec_rs2_addr = 7;
    hz.ex_write_reg = 1; hz.ex_dstreg_addr = 7;
    hz.mem_write_reg = 1; hz.mem_dstreg_addr = 7;
    #1;
    checks++;
    if (hz.fwd_rs2_sel !== 2'b01) begin fails++; $display("FAIL fwd_ex_prio: got %b want 01", hz.fwd_rs2_sel); end
    hz.ex_dstreg_addr = 8;
    #1;
    checks++;
    if (hz.fwd_rs2_sel !== 2'b10) begin fails++; $display("FAIL fwd_mem_rs2: got %b want 10", hz.fwd_rs2_sel); end
    hz.dec_uses_rs2 = 0;
    #1;
    checks++;
    if (hz.fwd_rs2_sel !== 2'b00) begin fails++; $display("FAIL fwd_unused: got %b want 00", hz.fwd_rs2_sel); end
    tick();
    set_idle();
    hz.dec_valid = 1; hz.dec_uses_rs1 = 1; hz.dec_uses_rs2 = 1;
    hz.ex_write_reg = 1; hz.ex_is_load = 1; hz.mem_write_reg = 1;
    #1;
    checks++;
    if (outs() !== 11'd0) begin fails++; $display("FAIL fwd_x0: got %b want %b", outs(), 11'd0); end
    tick();
    set_idle();
    $display("test_forwarding done");
  endtask

  task automatic test_load_use();
    set_idle();
    hz.dec_valid = 1; hz.dec_uses_rs1 = 1; hz.dec_rs1_addr = 3;
    hz.ex_write_reg = 1; hz.ex_is_load = 1; hz.ex_dstreg_addr = 3;
    #1;
    checks++;
    if ({hz.stall_f, hz.stall_d, hz.bubble_e} !== 3'b111) begin
      fails++; $display("FAIL ld_stall: got %b want 111", {hz.stall_f, hz.stall_d, hz.bubble_e});
    end
    tick();
    // load has advanced to MEM, EX now holds the bubble
    hz.ex_write_reg = 0; hz.ex_is_load = 0; hz.ex_dstreg_addr = 0;
    hz.mem_write_reg = 1; hz.mem_dstreg_addr = 3;
    #1;
    checks++;
    if ({hz.stall_f, hz.stall_d, hz.bubble_e} !== 3'b000) begin
      fails++; $display("FAIL ld_release: got %b want 000", {hz.stall_f, hz.stall_d, hz.bubble_e});
    end
    checks++;
    if (hz.fwd_rs1_sel !== 2'b10) begin fails++; $display("FAIL ld_fwd_mem: got %b want 10", hz.fwd_rs1_sel); end
    tick();
    set_idle();
    hz.dec_valid = 1; hz.dec_uses_rs2 = 1; hz.dec_rs1_addr = 3; hz.dec_rs2_addr = 4;
    hz.ex_write_reg = 1; hz.ex_is_load = 1; hz.ex_dstreg_addr = 3;
    #1;
    checks++;
    if (hz.stall_d !== 1'b0) begin fails++; $display("FAIL ld_unused_rs: got %b want 0", hz.stall_d); end
    tick();
    set_idle();
    $display("test_load_use done");
  endtask

  task automatic test_branch();
    set_idle();
    hz.br_taken = 1; hz.dec_valid = 1; hz.dec_multicycle = 1;
    hz.dec_uses_rs1 = 1; hz.dec_rs1_addr = 3;
    hz.ex_write_reg = 1; hz.ex_is_load = 1; hz.ex_dstreg_addr = 3;
    #1;
    checks++;
    if ({hz.flush_fd, hz.stall_f, hz.stall_d, hz.bubble_e, hz.md_start} !== 5'b10000) begin
      fails++; $display("FAIL br_cycle0: got %b want 10000", {hz.flush_fd, hz.stall_f, hz.stall_d, hz.bubble_e, hz.md_start});
    end
    tick();
    hz.br_taken = 0;
    #1;
    checks++;
    if ({hz.flush_fd, hz.stall_d, hz.md_start} !== 3'b100) begin
      fails++; $display("FAIL br_cycle1: got %b want 100", {hz.flush_fd, hz.stall_d, hz.md_start});
    end
    tick();
    checks++;
    if ({hz.flush_fd, hz.stall_d, hz.bubble_e} !== 3'b011) begin
      fails++; $display("FAIL br_back_to_run: got %b want 011", {hz.flush_fd, hz.stall_d, hz.bubble_e});
    end
    set_idle();
    tick();
    $display("test_branch done");
  endtask

  task automatic test_multicycle();
    set_idle();
    hz.dec_valid = 1; hz.dec_multicycle = 1;
    #1;
    checks++;
    if ({hz.md_start, hz.ex_hold, hz.stall_d} !== 3'b100) begin
      fails++; $display("FAIL md_start: got %b want 100", {hz.md_start, hz.ex_hold, hz.stall_d});
    end
    tick();
    set_idle();
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if ({hz.ex_hold, hz.stall_f, hz.stall_d, hz.md_start, hz.md_done} !== {4'b1110, (i == 4)}) begin
        fails++; $display("FAIL md_cycle%0d: got %b want %b", i,
          {hz.ex_hold, hz.stall_f, hz.stall_d, hz.md_start, hz.md_done}, {4'b1110, (i == 4)});
      end
      tick();
    end
    checks++;
    if ({hz.ex_hold, hz.stall_f, hz.md_done} !== 3'b000) begin
      fails++; $display("FAIL md_release: got %b want 000", {hz.ex_hold, hz.stall_f, hz.md_done});
    end
    $display("test_multicycle done");
  endtask

  task automatic test_back_to_back();
    int starts = 0, dones = 0, holds = 0;
    set_idle();
    hz.dec_valid = 1; hz.dec_multicycle = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      starts += int'(hz.md_start);
      dones  += int'(hz.md_done);
      holds  += int'(hz.ex_hold);
      tick();
    end
    set_idle();
    checks++;
    if ({starts, dones, holds} !== {32'd2, 32'd2, 32'd8}) begin
      fails++; $display("FAIL b2b_counts: got start=%0d done=%0d hold=%0d want 2/2/8", starts, dones, holds);
    end
    tick();
    checks++;
    if (hz.ex_hold !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", hz.ex_hold); end
    $display("test_back_to_back done");
  endtask

  task automatic test_md_reset();
    int late_events = 0;
    set_idle();
    hz.dec_valid = 1; hz.dec_multicycle = 1;
    tick();
    set_idle();
    #1;
    checks++;
    if (hz.ex_hold !== 1'b1) begin fails++; $display("FAIL mdrst_cycle1: got %b want 1", hz.ex_hold); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 11'd0) begin fails++; $display("FAIL mdrst_async: got %b want %b", outs(), 11'd0); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      late_events += int'(hz.md_done | hz.ex_hold);
      tick();
    end
    checks++;
    if (late_events !== 0) begin fails++; $display("FAIL mdrst_no_done: got %0d want 0", late_events); end
    $display("test_md_reset done");
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multicycle();
    test_back_to_back();
    test_md_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
